// File: rtl/vga_text_writer_pkg.sv
// Shared constants and state encoding for the text-mode character RAM writer.
package vga_text_writer_pkg;

    localparam int COLS = 70;
    localparam int ROWS = 30;

    localparam logic [6:0] X_LAST = 7'(COLS - 1);
    localparam logic [6:0] Y_LAST = 7'(ROWS - 1);
    localparam logic [6:0] Y_SCROLL_LAST = 7'(ROWS - 2);

    localparam logic [7:0] ASC_SPACE    = 8'h20;
    localparam logic [7:0] ASC_BS       = 8'h08;
    localparam logic [7:0] ASC_CR       = 8'h0D;
    localparam logic [7:0] ASC_LF       = 8'h0A;
    localparam logic [7:0] ASC_PRINT_LO = 8'h20;
    localparam logic [7:0] ASC_PRINT_HI = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCR_RD  = 3'd1,
        ST_SCR_WR  = 3'd2,
        ST_SCR_CLR = 3'd3,
        ST_CLR     = 3'd4
    } state_e;

    // True for bytes that occupy a character cell on screen.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASC_PRINT_LO) && (c <= ASC_PRINT_HI);
    endfunction

endpackage

// File: rtl/vga_text_writer_blink_div.sv
// Toggle divider: blink_en flips once every DIV clock cycles.
module vga_text_writer_blink_div #(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic clrn,
    output logic blink_en
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_r;
    logic             blink_r;

    // Free-running cycle counter; toggles the blink phase at each wrap.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_r   <= '0;
            blink_r <= 1'b0;
        end else if (cnt_r == CNT_W'(DIV - 1)) begin
            cnt_r   <= '0;
            blink_r <= ~blink_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end

    assign blink_en = blink_r;

endmodule

// File: rtl/vga_text_writer.sv
// Character RAM writer: cursor handling, newline/backspace, scroll and clear.
module vga_text_writer
    import vga_text_writer_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       wr_en,
    output logic [6:0] wr_x,
    output logic [6:0] wr_y,
    output logic [7:0] wr_data,
    output logic [6:0] rd_x,
    output logic [6:0] rd_y,
    input  logic [7:0] rd_data,
    output logic [6:0] cursor_x,
    output logic [6:0] cursor_y,
    output logic       blink_en
);

    state_e     state_r, state_nxt_s;
    logic [6:0] cur_x_r, cur_y_r, cur_x_nxt_s, cur_y_nxt_s;
    logic [6:0] scan_x_r, scan_y_r, scan_x_nxt_s, scan_y_nxt_s;
    logic [6:0] rd_x_r, rd_y_r, rd_x_nxt_s, rd_y_nxt_s;
    logic [6:0] wr_x_r, wr_y_r, wr_x_nxt_s, wr_y_nxt_s;
    logic [7:0] wr_data_r, wr_data_nxt_s;
    logic       wr_en_r, wr_en_nxt_s;
    logic       nl_req_s;
    logic       accept_s, nl_byte_s, scroll_s;

    assign accept_s  = (state_r == ST_IDLE) && !clear_req && char_valid;
    assign nl_byte_s = (char_data == ASC_CR) || (char_data == ASC_LF);
    // A newline on the bottom row (explicit or from end-of-line wrap) scrolls.
    assign scroll_s  = accept_s && (cur_y_r == Y_LAST) &&
                       (nl_byte_s || (is_printable(char_data) && (cur_x_r == X_LAST)));

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt_s = ST_CLR;
                end else if (scroll_s) begin
                    state_nxt_s = ST_SCR_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCR_RD: state_nxt_s = ST_SCR_WR;
            ST_SCR_WR: begin
                if ((scan_x_r == X_LAST) && (scan_y_r == Y_SCROLL_LAST)) begin
                    state_nxt_s = ST_SCR_CLR;
                end else begin
                    state_nxt_s = ST_SCR_RD;
                end
            end
            ST_SCR_CLR: begin
                if (scan_x_r == X_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SCR_CLR;
                end
            end
            ST_CLR: begin
                if ((scan_x_r == X_LAST) && (scan_y_r == Y_LAST)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLR;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of cursor, scan pointer and the registered RAM ports.
    always_comb begin
        cur_x_nxt_s   = cur_x_r;
        cur_y_nxt_s   = cur_y_r;
        scan_x_nxt_s  = scan_x_r;
        scan_y_nxt_s  = scan_y_r;
        rd_x_nxt_s    = rd_x_r;
        rd_y_nxt_s    = rd_y_r;
        wr_en_nxt_s   = 1'b0;
        wr_x_nxt_s    = wr_x_r;
        wr_y_nxt_s    = wr_y_r;
        wr_data_nxt_s = wr_data_r;
        nl_req_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    cur_x_nxt_s  = 7'd0;
                    cur_y_nxt_s  = 7'd0;
                    scan_x_nxt_s = 7'd0;
                    scan_y_nxt_s = 7'd0;
                end else if (char_valid) begin
                    if (is_printable(char_data)) begin
                        wr_en_nxt_s   = 1'b1;
                        wr_x_nxt_s    = cur_x_r;
                        wr_y_nxt_s    = cur_y_r;
                        wr_data_nxt_s = char_data;
                        if (cur_x_r != X_LAST) begin
                            cur_x_nxt_s = cur_x_r + 7'd1;
                        end else begin
                            cur_x_nxt_s = 7'd0;
                            nl_req_s    = 1'b1;
                        end
                    end else if (nl_byte_s) begin
                        cur_x_nxt_s = 7'd0;
                        nl_req_s    = 1'b1;
                    end else if (char_data == ASC_BS) begin
                        if (cur_x_r != 7'd0) begin
                            cur_x_nxt_s   = cur_x_r - 7'd1;
                            wr_en_nxt_s   = 1'b1;
                            wr_x_nxt_s    = cur_x_r - 7'd1;
                            wr_y_nxt_s    = cur_y_r;
                            wr_data_nxt_s = ASC_SPACE;
                        end else if (cur_y_r != 7'd0) begin
                            cur_x_nxt_s   = X_LAST;
                            cur_y_nxt_s   = cur_y_r - 7'd1;
                            wr_en_nxt_s   = 1'b1;
                            wr_x_nxt_s    = X_LAST;
                            wr_y_nxt_s    = cur_y_r - 7'd1;
                            wr_data_nxt_s = ASC_SPACE;
                        end else begin
                            wr_en_nxt_s = 1'b0;
                        end
                    end else begin
                        wr_en_nxt_s = 1'b0;
                    end
                end else begin
                    wr_en_nxt_s = 1'b0;
                end
            end
            ST_SCR_RD: begin
                wr_en_nxt_s = 1'b0;
            end
            ST_SCR_WR: begin
                wr_en_nxt_s   = 1'b1;
                wr_x_nxt_s    = scan_x_r;
                wr_y_nxt_s    = scan_y_r;
                wr_data_nxt_s = rd_data;
                if (scan_x_r == X_LAST) begin
                    scan_x_nxt_s = 7'd0;
                    scan_y_nxt_s = scan_y_r + 7'd1;
                end else begin
                    scan_x_nxt_s = scan_x_r + 7'd1;
                end
            end
            ST_SCR_CLR: begin
                wr_en_nxt_s   = 1'b1;
                wr_x_nxt_s    = scan_x_r;
                wr_y_nxt_s    = Y_LAST;
                wr_data_nxt_s = ASC_SPACE;
                scan_x_nxt_s  = scan_x_r + 7'd1;
            end
            ST_CLR: begin
                wr_en_nxt_s   = 1'b1;
                wr_x_nxt_s    = scan_x_r;
                wr_y_nxt_s    = scan_y_r;
                wr_data_nxt_s = ASC_SPACE;
                if (scan_x_r == X_LAST) begin
                    scan_x_nxt_s = 7'd0;
                    scan_y_nxt_s = scan_y_r + 7'd1;
                end else begin
                    scan_x_nxt_s = scan_x_r + 7'd1;
                end
            end
            default: begin
                wr_en_nxt_s = 1'b0;
            end
        endcase
        // Newline: step down, or on the bottom row start the scroll scan at (0,0).
        if (nl_req_s) begin
            if (cur_y_r != Y_LAST) begin
                cur_y_nxt_s = cur_y_r + 7'd1;
            end else begin
                scan_x_nxt_s = 7'd0;
                scan_y_nxt_s = 7'd0;
            end
        end else begin
            cur_y_nxt_s = cur_y_nxt_s;
        end
        // Present the source cell (one row below) during every SCR_RD cycle.
        if (state_nxt_s == ST_SCR_RD) begin
            rd_x_nxt_s = scan_x_nxt_s;
            rd_y_nxt_s = scan_y_nxt_s + 7'd1;
        end else begin
            rd_x_nxt_s = rd_x_r;
            rd_y_nxt_s = rd_y_r;
        end
    end

    // Datapath registers; RAM contents are deliberately untouched by reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cur_x_r   <= 7'd0;
            cur_y_r   <= 7'd0;
            scan_x_r  <= 7'd0;
            scan_y_r  <= 7'd0;
            rd_x_r    <= 7'd0;
            rd_y_r    <= 7'd0;
            wr_en_r   <= 1'b0;
            wr_x_r    <= 7'd0;
            wr_y_r    <= 7'd0;
            wr_data_r <= 8'd0;
        end else begin
            cur_x_r   <= cur_x_nxt_s;
            cur_y_r   <= cur_y_nxt_s;
            scan_x_r  <= scan_x_nxt_s;
            scan_y_r  <= scan_y_nxt_s;
            rd_x_r    <= rd_x_nxt_s;
            rd_y_r    <= rd_y_nxt_s;
            wr_en_r   <= wr_en_nxt_s;
            wr_x_r    <= wr_x_nxt_s;
            wr_y_r    <= wr_y_nxt_s;
            wr_data_r <= wr_data_nxt_s;
        end
    end

    // Ready only in IDLE, and withheld while a clear request takes priority.
    always_comb begin
        char_ready = 1'b0;
        if ((state_r == ST_IDLE) && !clear_req) begin
            char_ready = 1'b1;
        end else begin
            char_ready = 1'b0;
        end
    end

    assign wr_en    = wr_en_r;
    assign wr_x     = wr_x_r;
    assign wr_y     = wr_y_r;
    assign wr_data  = wr_data_r;
    assign rd_x     = rd_x_r;
    assign rd_y     = rd_y_r;
    assign cursor_x = cur_x_r;
    assign cursor_y = cur_y_r;

    vga_text_writer_blink_div #(
        .DIV (BLINK_DIV)
    ) u_blink_div (
        .clk      (clk),
        .clrn     (clrn),
        .blink_en (blink_en)
    );

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer with a write scoreboard and a RAM model.
module tb_vga_text_writer;

    logic       clk = 1'b0;
    logic       clrn;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       clear_req;
    logic       wr_en;
    logic [6:0] wr_x, wr_y, rd_x, rd_y, cursor_x, cursor_y;
    logic [7:0] wr_data, rd_data;
    logic       blink_en;

    always #5 clk = ~clk;

    vga_text_writer #(.BLINK_DIV(4)) dut (
        .clk(clk), .clrn(clrn), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .clear_req(clear_req), .wr_en(wr_en),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .rd_x(rd_x), .rd_y(rd_y),
        .rd_data(rd_data), .cursor_x(cursor_x), .cursor_y(cursor_y), .blink_en(blink_en)
    );

    // Synchronous character RAM the DUT writes into and scrolls from.
    logic [7:0] ram [0:127][0:127];
    always @(posedge clk) begin
        if (wr_en) ram[wr_y][wr_x] <= wr_data;
        rd_data <= ram[rd_y][rd_x];
    end

    typedef struct packed { logic [6:0] x; logic [6:0] y; logic [7:0] d; } wr_t;
    wr_t        exp_q[$];
    logic [7:0] exp_ram [0:29][0:69];
    int checks = 0, errors = 0, wr_cnt = 0;
    int mx = 0, my = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int x, input int y, input logic [7:0] d);
        wr_t e;
        e.x = 7'(x); e.y = 7'(y); e.d = d;
        exp_q.push_back(e);
        exp_ram[y][x] = d;
    endtask

    // Advance one clock; sample 1 time unit after the edge and score any write.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (wr_en) begin
            wr_cnt++;
            chk("wr_pending", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_xyd", {10'd0, wr_x, wr_y, wr_data}, {10'd0, e});
            end
        end
    endtask

    task automatic push_scroll();
        for (int y = 0; y < 29; y++)
            for (int x = 0; x < 70; x++)
                push(x, y, exp_ram[y + 1][x]);
        for (int x = 0; x < 70; x++) push(x, 29, 8'h20);
    endtask

    task automatic newline();
        if (my < 29) my++;
        else push_scroll();
    endtask

    // Reference behaviour of one accepted byte.
    task automatic model(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push(mx, my, b);
            if (mx < 69) mx++;
            else begin mx = 0; newline(); end
        end else if (b == 8'h0D || b == 8'h0A) begin
            mx = 0; newline();
        end else if (b == 8'h08) begin
            if (mx > 0) begin mx--; push(mx, my, 8'h20); end
            else if (my > 0) begin mx = 69; my--; push(mx, my, 8'h20); end
        end
    endtask

    task automatic send(input logic [7:0] b, input bit hold);
        model(b);
        char_valid = 1'b1;
        char_data  = b;
        chk("char_ready", char_ready, 1);
        tick();
        if (!hold) char_valid = 1'b0;
    endtask

    task automatic wait_idle(output int busy);
        busy = 0;
        while (char_ready !== 1'b1 && busy < 10000) begin
            busy++;
            tick();
        end
        chk("idle_timeout", (busy < 10000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic chk_cursor(input string tag, input int x, input int y);
        chk(tag, {18'd0, cursor_x, cursor_y}, {18'd0, 7'(x), 7'(y)});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_xy"}, {wr_x, wr_y}, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_rd_xy"}, {rd_x, rd_y}, 0);
        chk_cursor({tag, "_cursor"}, 0, 0);
        chk({tag, "_blink"}, blink_en, 0);
    endtask

    initial begin
        int busy, w0, t, mism;
        logic prev;
        clrn = 1'b0; char_valid = 1'b0; char_data = 8'h00; clear_req = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        clrn = 1'b1;
        tick();
        chk("ready_after_reset", char_ready, 1);

        // Blink phase period with BLINK_DIV=4.
        prev = blink_en; t = 0;
        while (blink_en === prev && t < 20) begin tick(); t++; end
        for (int k = 0; k < 2; k++) begin
            prev = blink_en; t = 0;
            while (blink_en === prev && t < 20) begin tick(); t++; end
            chk("blink_period", t, 4);
        end

        // Screen clear.
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 70; x++) push(x, y, 8'h20);
        mx = 0; my = 0;
        w0 = wr_cnt;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_idle(busy);
        chk("clr_busy", busy, 2100);
        chk("clr_writes", wr_cnt - w0, 2100);
        chk("clr_q_empty", exp_q.size(), 0);
        chk_cursor("clr_cursor", 0, 0);

        // Backspace at the home position does nothing.
        w0 = wr_cnt;
        send(8'h08, 1'b0); tick();
        chk("bs_home_writes", wr_cnt - w0, 0);
        chk_cursor("bs_home_cursor", 0, 0);

        // Back-to-back 'A','B'.
        send(8'h41, 1'b1); send(8'h42, 1'b0); tick();
        chk_cursor("ab_cursor", 2, 0);
        chk("ab_q_empty", exp_q.size(), 0);

        // Non-printable, non-control byte is swallowed.
        w0 = wr_cnt;
        send(8'h7F, 1'b0); tick();
        chk("other_writes", wr_cnt - w0, 0);
        chk_cursor("other_cursor", 2, 0);

        // Backspace from column 0 wraps to the end of the previous row.
        for (int i = 0; i < 3; i++) send(8'h0A, 1'b0);
        chk_cursor("lf3_cursor", 0, 3);
        send(8'h08, 1'b0); tick();
        chk_cursor("bs_wrap_cursor", 69, 2);
        chk("bs_wrap_ram", ram[2][69], 8'h20);

        // A full row of printable bytes wraps onto the next row.
        for (int i = 0; i < 3; i++) send(8'h0A, 1'b0);
        for (int i = 0; i < 70; i++) send(8'(8'h21 + i), (i < 69));
        tick();
        chk_cursor("row5_cursor", 0, 6);
        chk("row5_last", ram[5][69], 8'h66);
        chk("row5_q_empty", exp_q.size(), 0);

        // Move to (10,29).
        for (int i = 0; i < 23; i++) send(8'h0A, 1'b0);
        chk_cursor("bottom_cursor", 0, 29);
        for (int i = 0; i < 10; i++) send(8'(8'h30 + i), 1'b0);
        chk_cursor("bottom10_cursor", 10, 29);

        // CR on the bottom row scrolls the whole screen.
        w0 = wr_cnt;
        send(8'h0D, 1'b0);
        wait_idle(busy);
        chk("scroll_busy", busy, 4130);
        chk("scroll_writes", wr_cnt - w0, 2100);
        chk("scroll_q_empty", exp_q.size(), 0);
        chk_cursor("scroll_cursor", 0, 29);
        mism = 0;
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 70; x++)
                if (ram[y][x] !== exp_ram[y][x]) mism++;
        chk("scroll_ram_image", mism, 0);
        chk("scroll_row4_moved", ram[4][68], 8'h65);

        // Reset in the middle of a scroll aborts immediately.
        send(8'h0A, 1'b0);
        repeat (150) tick();
        chk("midscroll_busy", char_ready, 0);
        #2 clrn = 1'b0;
        #1;
        chk_reset_outputs("midscroll_reset");
        exp_q.delete();
        tick();
        clrn = 1'b1;
        tick();
        chk("ready_after_abort", char_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_text_writer.md
# vga_text_writer

Writer side of the text-mode character RAM scanned by the VGA character renderer. Accepts ASCII bytes from the keyboard path over a valid/ready handshake and writes them into the 70×30 character RAM. Maintains the cursor (cursor_x, cursor_y) and handles newline, backspace, end-of-line wrap, whole-screen scroll and screen clear. Also generates the cursor blink enable.

## Interface
- COLS, 70: characters per row (cursor_x 0..69).
- ROWS, 30: character rows (cursor_y 0..29).
- BLINK_DIV, 25_000_000: clk cycles per blink_en toggle.
- clk  in  1  system clock; all state changes on posedge.
- clrn  in  1  asynchronous active-low reset.
- char_valid  in  1  ASCII byte present on char_data.
- char_data  in  8  ASCII byte.
- char_ready  out  1  high only in IDLE; byte consumed on clk edge with char_valid & char_ready.
- clear_req  in  1  clear-screen request, sampled only in IDLE.
- wr_en  out  1  RAM write strobe, one cycle per write.
- wr_x  out  7  RAM write column.
- wr_y  out  7  RAM write row.
- wr_data  out  8  byte written.
- rd_x  out  7  RAM read column (scroll only).
- rd_y  out  7  RAM read row (scroll only).
- rd_data  in  8  RAM read data, valid one clk after rd_x/rd_y.
- cursor_x  out  7  cursor column, registered.
- cursor_y  out  7  cursor row, registered.
- blink_en  out  1  cursor blink phase.

## Operation
- States: IDLE, SCR_RD, SCR_WR, SCR_CLR, CLR.
- IDLE, clear_req=1 (priority over char_valid): go to CLR, cursor→(0,0), char_ready low.
- IDLE, byte accepted:
  - 0x20–0x7E: write byte at cursor. Then, if cursor_x<69, x+1. Otherwise x=0 and newline.
  - 0x0D or 0x0A: x=0, newline. No RAM write.
  - 0x08: if x>0, x-1. Else if y>0, x=69, y-1. Else no effect. On move, write 0x20 at the new position.
  - Any other byte: accepted, no effect.
- Newline: if y<29, y+1 and stay in IDLE. If y=29, y stays 29 and go to SCR_RD with scan (x=0, y=0).
- SCR_RD: rd=(x, y+1). Next state SCR_WR.
- SCR_WR: write rd_data to (x, y). Advance x, then y. After (69, 28), go to SCR_CLR. Otherwise return to SCR_RD.
- SCR_CLR: write 0x20 to (x, 29), x=0..69 one per cycle, then IDLE.
- CLR: write 0x20 to every cell in row-major order, (0,0)..(69,29), then IDLE.
- Arithmetic: x and y compare against COLS-1 and ROWS-1 exactly. There is no modulo wrap of y; y never exceeds 29.
- blink_en: a counter counts 0..BLINK_DIV-1 and blink_en toggles at wrap. It runs in all states.
- RAM contents are not touched by reset. Software or the keyboard path issues clear_req after power-up.

## Timing
- Reset (asynchronous, clrn=0): state=IDLE, cursor=(0,0), wr_en=0, wr_x=wr_y=0, wr_data=0, rd_x=rd_y=0, blink_en=0, blink counter=0. char_ready=1 once clrn deasserts.
- Printable or backspace accepted at edge T: wr_en, wr_x, wr_y and wr_data are registered at T, so the write is visible during cycle T..T+1. The cursor update lands on the same edge.
- wr_en is high for exactly one cycle per write and low in IDLE unless a write was just issued.
- Back-to-back bytes: one byte per cycle in IDLE.
- Scroll: 2 cycles per cell × 2030 cells + 70 clear cycles = 4130 cycles with char_ready=0. The printable-char write that triggers the scroll lands before the first SCR_RD.
- CLR: 2100 cycles, char_ready=0.
- clear_req or char_valid asserted while busy: ignored until IDLE. The sender holds char_valid and char_data stable until accepted.
- Reset mid-scroll or mid-clear: aborts immediately. Partially moved RAM is left as-is.

## Structure
- Shared package: COLS, ROWS, and ASCII constants (ASC_SPACE=0x20, ASC_BS=0x08, ASC_CR=0x0D, ASC_LF=0x0A, printable range bounds), plus the state encoding.
- Sub-module: blink_div, a parameterised toggle divider (clk, clrn, DIV → blink_en). All other logic stays in one FSM.

## Test plan
- Reset, clear_req pulse, count 2100 wr_en cycles all with wr_data=0x20 → ends with cursor (0,0) and char_ready=1.
- Send 'A','B' from (0,0) → writes (0,0)=0x41 and (1,0)=0x42, cursor (2,0).
- Send 70 printable bytes at row 5 → last byte written at (69,5), cursor (0,6).
- Backspace at (0,3) → space written at (69,2), cursor (69,2). Backspace at (0,0) → no wr_en, cursor unchanged.
- Cursor (10,29), send 0x0D → 2030 copies, each row r+1 to row r (check via RAM model), row 29 all 0x20, cursor (0,29), 4130 busy cycles.
- BLINK_DIV=4 → blink_en toggles every 4 cycles. Assert clrn=0 mid-scroll → all outputs return to reset values at once.
